// File: rtl/dprintf_uart_tx.sv
// Byte FIFO plus 8N1 UART transmitter for dprintf output.
// Optional CR/LF insertion on address discontinuity: define DPRINTF_UART_NEWLINE_EN.
module dprintf_uart_tx #(
  parameter int CLK_DIV   = 868,
  parameter int FIFO_LOG2 = 4
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset,
  input  logic        dprintf_byte__valid,
  input  logic [7:0]  dprintf_byte__data,
  input  logic [15:0] dprintf_byte__address,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic [15:0] overflow_count
);
  localparam int DEPTH = 1 << FIFO_LOG2;
`ifdef DPRINTF_UART_NEWLINE_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif
  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [FIFO_LOG2:0] wr_ptr;
  logic [FIFO_LOG2:0] rd_ptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] push_entry;
  logic               head_flag;

  state_t      state;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  pend_data;
  logic [1:0]  nl_phase;
  logic        bit_end;
  logic        frame_start;
  logic        ld_any;
  logic        ld_pop;
  logic [7:0]  ld_byte;
  logic [7:0]  ld_pend;
  logic [1:0]  ld_phase;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                      (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
  assign push       = dprintf_byte__valid && !fifo_full;
  assign head       = mem[rd_ptr[FIFO_LOG2-1:0]];

`ifdef DPRINTF_UART_NEWLINE_EN
  logic        have_prev;
  logic [15:0] last_addr;
  logic        push_flag;

  // A jump in character position means a new line started in the formatter.
  assign push_flag  = have_prev && ((last_addr + 16'd1) != dprintf_byte__address);
  assign push_entry = {push_flag, dprintf_byte__data};
  assign head_flag  = head[8];

  always_ff @(posedge clk) begin
    if (clk__enable) begin
      if (reset) begin
        have_prev <= 1'b0;
        last_addr <= '0;
      end else if (push) begin
        have_prev <= 1'b1;
        last_addr <= dprintf_byte__address;
      end
    end
  end
`else
  logic unused_addr;

  assign unused_addr = ^dprintf_byte__address;
  assign push_entry  = dprintf_byte__data;
  assign head_flag   = 1'b0;
`endif

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (clk__enable && push) begin
      mem[wr_ptr[FIFO_LOG2-1:0]] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (clk__enable) begin
      if (reset) begin
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        overflow_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (dprintf_byte__valid && fifo_full) overflow_count <= sat_inc(overflow_count);
      end
    end
  end

  // Next frame source: pending LF, pending data after CR/LF, or the FIFO head
  always_comb begin
    ld_any   = 1'b0;
    ld_pop   = 1'b0;
    ld_byte  = head[7:0];
    ld_pend  = pend_data;
    ld_phase = 2'd0;
    if (nl_phase == 2'd2) begin
      ld_any   = 1'b1;
      ld_byte  = 8'h0A;
      ld_phase = 2'd1;
    end else if (nl_phase == 2'd1) begin
      ld_any  = 1'b1;
      ld_byte = pend_data;
    end else if (!fifo_empty) begin
      ld_any = 1'b1;
      ld_pop = 1'b1;
      if (head_flag) begin
        ld_byte  = 8'h0D;
        ld_pend  = head[7:0];
        ld_phase = 2'd2;
      end
    end
  end

  assign bit_end     = (timer == BIT_LAST);
  assign frame_start = ld_any && ((state == IDLE) || ((state == STOP) && bit_end));
  assign pop         = frame_start && ld_pop;
  assign tx_busy     = (state != IDLE) || !fifo_empty;

  // Transmit FSM
  always_ff @(posedge clk) begin
    if (clk__enable) begin
      if (reset) begin
        state    <= IDLE;
        timer    <= '0;
        bit_idx  <= '0;
        nl_phase <= '0;
        uart_txd <= 1'b1;
      end else if (frame_start) begin
        state     <= START;
        timer     <= '0;
        uart_txd  <= 1'b0;
        shreg     <= ld_byte;
        pend_data <= ld_pend;
        nl_phase  <= ld_phase;
      end else begin
        case (state)
          IDLE: uart_txd <= 1'b1;
          START: begin
            if (bit_end) begin
              timer    <= '0;
              state    <= DATA;
              bit_idx  <= '0;
              uart_txd <= shreg[0];
              shreg    <= {1'b0, shreg[7:1]};
            end else begin
              timer <= timer + 16'd1;
            end
          end
          DATA: begin
            if (bit_end) begin
              timer <= '0;
              if (bit_idx == 3'd7) begin
                state    <= STOP;
                uart_txd <= 1'b1;
              end else begin
                bit_idx  <= bit_idx + 3'd1;
                uart_txd <= shreg[0];
                shreg    <= {1'b0, shreg[7:1]};
              end
            end else begin
              timer <= timer + 16'd1;
            end
          end
          STOP: begin
            if (bit_end) begin
              timer <= '0;
              state <= IDLE;
            end else begin
              timer <= timer + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
